// File: rtl/boolfn_tt_scanner.sv
// ============================================================================
// Module      : boolfn_tt_scanner
// Description : Drives all 8 input vectors of a 3-input Boolean function,
//               captures its truth table and compares it against EXPECT.
//               Optional macro TT_ERRMASK_EN adds err_mask/err_cnt outputs.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module boolfn_tt_scanner #(
  parameter int          SETTLE = 2,
  parameter logic [7:0]  EXPECT = 8'hE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       match
`ifdef TT_ERRMASK_EN
  ,
  output logic [7:0] err_mask,
  output logic [3:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_RELOAD = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] w_tt_next;

  // Truth table including the bit captured this cycle, so match is valid in DONE.
  always_comb begin
    w_tt_next        = tt;
    w_tt_next[r_idx] = y_i;
  end

`ifdef TT_ERRMASK_EN
  logic [7:0] w_err;
  assign w_err = w_tt_next ^ EXPECT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= 4'd0;
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      c_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= 8'h00;
      match    <= 1'b0;
`ifdef TT_ERRMASK_EN
      err_mask <= 8'h00;
      err_cnt  <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state       <= S_DRIVE;
            r_idx         <= 3'd0;
            r_cnt         <= c_RELOAD;
            {a_o,b_o,c_o} <= 3'd0;
            busy          <= 1'b1;
            tt            <= 8'h00;
            match         <= 1'b0;
`ifdef TT_ERRMASK_EN
            err_mask      <= 8'h00;
            err_cnt       <= 4'd0;
`endif
          end
        end
        S_DRIVE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          tt <= w_tt_next;
          if (r_idx == 3'd7) begin
            r_state       <= S_DONE;
            {a_o,b_o,c_o} <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b1;
            match         <= (w_tt_next == EXPECT);
`ifdef TT_ERRMASK_EN
            err_mask      <= w_err;
            err_cnt       <= 4'($countones(w_err));
`endif
          end else begin
            r_state       <= S_DRIVE;
            r_idx         <= r_idx + 3'd1;
            r_cnt         <= c_RELOAD;
            {a_o,b_o,c_o} <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boolfn_tt_scanner.sv
// ============================================================================
// Module      : tb_boolfn_tt_scanner
// Description : Randomized/directed bench for boolfn_tt_scanner (SETTLE=2 and
//               SETTLE=1 instances) against a truth-table reference model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_boolfn_tt_scanner;

  localparam logic [7:0] EXP_DEF = 8'hE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       y0;
  logic       y1 = 1'b0;
  logic       a0, b0, c0, busy0, done0, match0;
  logic       a1, b1, c1, busy1, done1, match1;
  logic [7:0] tt0, tt1;
`ifdef TT_ERRMASK_EN
  logic [7:0] em0, em1;
  logic [3:0] ec0, ec1;
`endif

  int         mode = 0;
  logic [7:0] rnd_tt = 8'h00;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  function automatic logic fut(input int m, input logic [7:0] t, input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (m)
      0:       return (a & (b | c)) | (~b & ~(a | c));
      1:       return 1'b0;
      2:       return a ^ b ^ c;
      default: return t[v];
    endcase
  endfunction

  assign y0 = fut(mode, rnd_tt, {a0, b0, c0});

  boolfn_tt_scanner #(.SETTLE(2), .EXPECT(EXP_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_i(y0),
    .a_o(a0), .b_o(b0), .c_o(c0), .busy(busy0), .done(done0),
    .tt(tt0), .match(match0)
`ifdef TT_ERRMASK_EN
    , .err_mask(em0), .err_cnt(ec0)
`endif
  );

  boolfn_tt_scanner #(.SETTLE(1), .EXPECT(EXP_DEF)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_i(y1),
    .a_o(a1), .b_o(b1), .c_o(c1), .busy(busy1), .done(done1),
    .tt(tt1), .match(match1)
`ifdef TT_ERRMASK_EN
    , .err_mask(em1), .err_cnt(ec1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_tt(input int m, input logic [7:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = fut(m, t, 3'(i));
    return r;
  endfunction

  // One complete scan on instance sel with settle s; poke adds ignored starts.
  task automatic scan(input int sel, input int s, input logic [7:0] exp_tt, input bit poke);
    int         L;
    int         idx;
    logic [2:0] vec;
    logic       bz, dn, mt;
    logic [7:0] tv;
    L = 8 * (s + 1) + 1;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= L + 3; cyc++) begin
      start0 = 1'b0; start1 = 1'b0;
      if (poke && (cyc == 10 || cyc == L)) begin
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
      end
      if (sel == 1) begin
        // Wrong value while driving, true value only in the sample cycle.
        y1 = fut(mode, rnd_tt, {a1, b1, c1});
        if ((cyc - 1) % (s + 1) != s) y1 = ~y1;
      end
      @(negedge clk);
      vec = (sel == 1) ? {a1, b1, c1} : {a0, b0, c0};
      bz  = (sel == 1) ? busy1 : busy0;
      dn  = (sel == 1) ? done1 : done0;
      mt  = (sel == 1) ? match1 : match0;
      tv  = (sel == 1) ? tt1 : tt0;
      chk("busy", 32'(bz), 32'(cyc <= L - 1));
      chk("done", 32'(dn), 32'(cyc == L));
      if (cyc <= L - 1) begin
        idx = (cyc - 1) / (s + 1);
        chk("vector", 32'(vec), 32'(idx));
      end
      if (cyc > L) chk("idle_vector", 32'(vec), 32'd0);
      if (cyc == L || cyc == L + 3) begin
        chk("tt", 32'(tv), 32'(exp_tt));
        chk("match", 32'(mt), 32'(exp_tt == EXP_DEF));
`ifdef TT_ERRMASK_EN
        chk("err_mask", 32'((sel == 1) ? em1 : em0), 32'(exp_tt ^ EXP_DEF));
        begin
          int pc;
          pc = 0;
          for (int i = 0; i < 8; i++) if (exp_tt[i] != EXP_DEF[i]) pc++;
          chk("err_cnt", 32'((sel == 1) ? ec1 : ec0), 32'(pc));
        end
`endif
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_vec", 32'({a0, b0, c0}), 32'd0);
    chk("rst_tt", 32'(tt0), 32'd0);
    chk("rst_match", 32'(match0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default equation, with ignored starts at cycle 10 and in DONE.
    mode = 0;
    e = model_tt(0, 8'h00);
    chk("model_default", 32'(e), 32'hE1);
    scan(0, 2, e, 1'b1);

    mode = 1;
    scan(0, 2, model_tt(1, 8'h00), 1'b0);

    mode = 2;
    e = model_tt(2, 8'h00);
    chk("model_xor", 32'(e), 32'h96);
    scan(0, 2, e, 1'b0);

    mode = 3;
    for (int k = 0; k < 3; k++) begin
      rnd_tt = 8'($urandom);
      if (k == 0) rnd_tt = EXP_DEF;
      scan(0, 2, model_tt(3, rnd_tt), 1'b0);
    end

    // Reset during vector 4 (cycles 13..15 at SETTLE=2).
    mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (13) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_vec", 32'({a0, b0, c0}), 32'd0);
    chk("abort_tt", 32'(tt0), 32'd0);
    chk("abort_match", 32'(match0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_done", 32'(done0), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done0), 32'd0);
      chk("post_abort_busy", 32'(busy0), 32'd0);
    end
    scan(0, 2, model_tt(0, 8'h00), 1'b0);

    // SETTLE=1 instance with y_i corrupted outside the sample cycle.
    mode = 0;
    scan(1, 1, model_tt(0, 8'h00), 1'b0);
    mode = 3;
    for (int k = 0; k < 2; k++) begin
      rnd_tt = 8'($urandom);
      scan(1, 1, model_tt(3, rnd_tt), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
